// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - PC sequencer with run-control FSM, jump LUT and return stack
module pc_sequencer #(
  parameter int PC_W        = 10,
  parameter int START_PC    = 0,
  parameter int STACK_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           done_i,
  input  logic                           stall,
  input  logic                           jmp_rel_en,
  input  logic [7:0]                     jmp_off,
  input  logic                           ljp_en,
  input  logic [1:0]                     ljp_sel,
  input  logic                           call_en,
  input  logic [PC_W-1:0]                call_tgt,
  input  logic                           ret_en,
  input  logic                           lut_we,
  input  logic [1:0]                     lut_widx,
  input  logic [PC_W-1:0]                lut_wdata,
  output logic [PC_W-1:0]                pc,
  output logic                           fetch_en,
  output logic                           running,
  output logic                           done_o,
  output logic                           fault,
  output logic [$clog2(STACK_DEPTH):0]   sp
);

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT, S_FAULT} state_t;

  state_t          r_state, w_state_nxt;
  logic [PC_W-1:0] r_pc, w_pc_nxt;
  logic [SP_W-1:0] r_sp, w_sp_nxt;
  logic [PC_W-1:0] r_lut   [4];
  logic [PC_W-1:0] r_stack [STACK_DEPTH];
  logic            w_push;

  logic [PC_W-1:0]  w_pc_inc;
  logic [PC_W-1:0]  w_off_ext;
  logic [IDX_W-1:0] w_top_idx;

  assign w_pc_inc  = r_pc + PC_W'(1);
  assign w_off_ext = {{(PC_W-8){jmp_off[7]}}, jmp_off};
  assign w_top_idx = IDX_W'(r_sp - SP_W'(1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and next PC/SP selection; strobes only matter in RUN without stall
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_sp_nxt    = r_sp;
    w_push      = 1'b0;
    case (r_state)
      S_RUN: begin
        if (!stall) begin
          if (done_i) begin
            w_state_nxt = S_HALT;
          end else if (ret_en) begin
            if (r_sp == '0) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_pc_nxt = r_stack[w_top_idx];
              w_sp_nxt = r_sp - SP_W'(1);
            end
          end else if (call_en) begin
            if (r_sp == SP_W'(STACK_DEPTH)) begin
              w_state_nxt = S_FAULT;
            end else begin
              w_push   = 1'b1;
              w_sp_nxt = r_sp + SP_W'(1);
              w_pc_nxt = call_tgt;
            end
          end else if (ljp_en) begin
            w_pc_nxt = r_lut[ljp_sel];
          end else if (jmp_rel_en) begin
            w_pc_nxt = r_pc + w_off_ext;
          end else begin
            w_pc_nxt = w_pc_inc;
          end
        end
      end
      default: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_pc_nxt    = PC_W'(START_PC);
          w_sp_nxt    = '0;
        end
      end
    endcase
  end

  // PC and stack pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= PC_W'(START_PC);
      r_sp <= '0;
    end else begin
      r_pc <= w_pc_nxt;
      r_sp <= w_sp_nxt;
    end
  end

  // Return stack: push the address after the call site
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STACK_DEPTH; i++) r_stack[i] <= '0;
    end else if (w_push) begin
      r_stack[r_sp[IDX_W-1:0]] <= w_pc_inc;
    end
  end

  // Jump-target LUT, writable in any state; same-cycle reads see the old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_lut[i] <= '0;
    end else if (lut_we) begin
      r_lut[lut_widx] <= lut_wdata;
    end
  end

  assign pc       = r_pc;
  assign sp       = r_sp;
  assign fetch_en = (r_state == S_RUN);
  assign running  = (r_state == S_RUN);
  assign done_o   = (r_state == S_HALT) || (r_state == S_FAULT);
  assign fault    = (r_state == S_FAULT);

endmodule
